ili_frame_sequencer: RTL

ILI_FRAME_SEQUENCER -- requirements
Module: ili_frame_sequencer

---
 rtl/ili_pkg.sv | 66 ++++++
 rtl/ili_init_rom.sv | 32 +++
 rtl/ili_frame_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ili_pkg.sv
// ----------------------------------------------------------------------------
// ili_pkg
// Shared definitions for the ILI-style panel frame sequencer:
//   - state_t     : sequencer state encoding (main phases plus send substates)
//   - ROM entry   : 10-bit init entries (bit 9 = delay flag, 10'h3FF = end)
//   - commands    : CASET / PASET / RAMWR opcodes
//   - win_word()  : the 11-word address-window preamble sent before each frame
// ----------------------------------------------------------------------------
package ili_pkg;

    typedef enum logic [3:0] {
        ST_HW_RST,      // panel reset held low
        ST_HW_WAIT,     // panel reset released, settling
        ST_INIT_FETCH,  // read next init ROM entry
        ST_DELAY,       // init-sequence millisecond delay
        ST_FRAME_IDLE,  // waiting for frame_go
        ST_WIN,         // stream the window preamble
        ST_PIX_HI,      // fetch pixel, send high byte
        ST_PIX_LO,      // send low byte
        ST_PIX_NEXT,    // advance pixel coordinates
        ST_ISSUE,       // send substate: strobe word into SPI master
        ST_WAIT_BUSY,   // send substate: wait for master to go busy
        ST_WAIT_DONE    // send substate: wait for master to finish
    } state_t;

    // Init ROM entry encoding.
    localparam int         ROM_AW        = 4;
    localparam int         ROM_DELAY_BIT = 9;
    localparam logic [9:0] ROM_END       = 10'h3FF;

    // Panel commands (sent with D/C = 0).
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam logic [3:0] WIN_WORDS = 4'd11;

    function automatic logic [9:0] rom_send(input logic [8:0] word);
        return {1'b0, word};
    endfunction

    function automatic logic [9:0] rom_delay(input logic [7:0] ms);
        return {1'b1, 1'b0, ms};
    endfunction

    // Window preamble: full-panel column range, full-panel row range, then
    // RAMWR. Start coordinates are always zero.
    function automatic logic [8:0] win_word(input logic [3:0]  idx,
                                            input logic [15:0] col_last,
                                            input logic [15:0] row_last);
        logic [8:0] word;
        case (idx)
            4'd0:       word = {1'b0, CMD_CASET};
            4'd1, 4'd2: word = 9'h100;
            4'd3:       word = {1'b1, col_last[15:8]};
            4'd4:       word = {1'b1, col_last[7:0]};
            4'd5:       word = {1'b0, CMD_PASET};
            4'd6, 4'd7: word = 9'h100;
            4'd8:       word = {1'b1, row_last[15:8]};
            4'd9:       word = {1'b1, row_last[7:0]};
            default:    word = {1'b0, CMD_RAMWR};
        endcase
        return word;
    endfunction

endpackage

// File: rtl/ili_init_rom.sv
// ----------------------------------------------------------------------------
// ili_init_rom
// Combinational panel init table. Each entry is either a word to send
// (bit 9 = 0, bits 8:0 = D/C + byte) or a delay in ms (bit 9 = 1, bits 7:0).
// Unused addresses read as END so the fetch loop always terminates.
// Ports:
//   i_index  in   ROM_AW  entry address
//   o_entry  out  10      entry contents
// ----------------------------------------------------------------------------
module ili_init_rom
    import ili_pkg::*;
(
    input  logic [ROM_AW-1:0] i_index,
    output logic [9:0]        o_entry
);

    always_comb begin
        // NOTE: every path of a combinational block must assign every output;
        // the default arm guarantees that here, so no latch is inferred.
        case (i_index)
            4'd0:    o_entry = rom_send(9'h001);   // software reset
            4'd1:    o_entry = rom_delay(8'd5);
            4'd2:    o_entry = rom_send(9'h011);   // sleep out
            4'd3:    o_entry = rom_delay(8'd120);
            4'd4:    o_entry = rom_send(9'h03A);   // pixel format
            4'd5:    o_entry = rom_send(9'h155);   //   16 bpp
            4'd6:    o_entry = rom_send(9'h029);   // display on
            default: o_entry = ROM_END;
        endcase
    end

endmodule

// File: rtl/ili_frame_sequencer.sv
// ----------------------------------------------------------------------------
// ili_frame_sequencer
// Drives an SPI master to bring up an ILI-style panel (hardware reset, init
// ROM playback) and then streams full RGB565 frames on request.
// Ports:
//   clk, rst      clock / synchronous active-low reset (shared with SPI master)
//   spi_idle      in   SPI master idle flag
//   spi_data      out  word to SPI master, bit 8 = D/C
//   spi_valid     out  one-cycle load strobe
//   lcd_rst_n     out  panel hardware reset
//   frame_go      in   level; start/continue frames (sampled in FRAME_IDLE)
//   pixel_data    in   RGB565 for (pixel_x, pixel_y)
//   pixel_x/y     out  current pixel coordinates
//   pixel_rd      out  one-cycle strobe, pixel_data sampled this cycle
//   init_done     out  sticky init-complete flag
//   frame_done    out  one-cycle pulse after the last pixel word
//   busy          out  high whenever not in FRAME_IDLE
// ----------------------------------------------------------------------------
module ili_frame_sequencer
    import ili_pkg::*;
#(
    parameter int DATA_SIZE    = 9,
    parameter int TICKS_PER_MS = 50000,
    parameter int WIDTH        = 240,
    parameter int HEIGHT       = 320,
    parameter int RST_HOLD_MS  = 10,
    parameter int RST_WAIT_MS  = 120
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_idle,
    output logic [DATA_SIZE-1:0] spi_data,
    output logic                 spi_valid,
    output logic                 lcd_rst_n,
    input  logic                 frame_go,
    input  logic [15:0]          pixel_data,
    output logic [8:0]           pixel_x,
    output logic [8:0]           pixel_y,
    output logic                 pixel_rd,
    output logic                 init_done,
    output logic                 frame_done,
    output logic                 busy
);

    localparam logic [31:0] HOLD_CYCLES = 32'(RST_HOLD_MS * TICKS_PER_MS);
    localparam logic [31:0] WAIT_CYCLES = 32'(RST_WAIT_MS * TICKS_PER_MS);
    localparam logic [8:0]  X_LAST      = 9'(WIDTH - 1);
    localparam logic [8:0]  Y_LAST      = 9'(HEIGHT - 1);
    localparam logic [15:0] COL_LAST    = 16'(WIDTH - 1);
    localparam logic [15:0] ROW_LAST    = 16'(HEIGHT - 1);

    state_t                r_state,    w_state_nxt;
    state_t                r_ret,      w_ret_nxt;   // caller to resume after a send
    logic [31:0]           r_cnt,      w_cnt_nxt;
    logic [ROM_AW-1:0]     r_rom_idx,  w_rom_idx_nxt;
    logic [3:0]            r_win_idx,  w_win_idx_nxt;
    logic [DATA_SIZE-1:0]  r_spi_data, w_spi_data_nxt;
    logic [7:0]            r_pix_lo,   w_pix_lo_nxt; // high byte goes out immediately
    logic [8:0]            r_x,        w_x_nxt;
    logic [8:0]            r_y,        w_y_nxt;
    logic                  r_init_done, w_init_done_nxt;
    logic [9:0]            w_entry;

    ili_init_rom u_rom (
        .i_index (r_rom_idx),
        .o_entry (w_entry)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            r_state     <= ST_HW_RST;
            r_ret       <= ST_FRAME_IDLE;
            r_cnt       <= HOLD_CYCLES;
            r_rom_idx   <= '0;
            r_win_idx   <= '0;
            r_spi_data  <= '0;
            r_pix_lo    <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret       <= w_ret_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rom_idx   <= w_rom_idx_nxt;
            r_win_idx   <= w_win_idx_nxt;
            r_spi_data  <= w_spi_data_nxt;
            r_pix_lo    <= w_pix_lo_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ret_nxt       = r_ret;
        w_cnt_nxt       = r_cnt;
        w_rom_idx_nxt   = r_rom_idx;
        w_win_idx_nxt   = r_win_idx;
        w_spi_data_nxt  = r_spi_data;
        w_pix_lo_nxt    = r_pix_lo;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_init_done_nxt = r_init_done;
        spi_valid       = 1'b0;
        pixel_rd        = 1'b0;
        frame_done      = 1'b0;

        case (r_state)
            // Counters are loaded on entry and run down to zero inclusive,
            // so a phase of N cycles-worth lasts N+1 cycles.
            ST_HW_RST: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_HW_WAIT;
                    w_cnt_nxt   = WAIT_CYCLES;
                end else begin
                    w_cnt_nxt   = r_cnt - 32'd1;
                end
            end

            ST_HW_WAIT, ST_DELAY: begin
                if (r_cnt == '0) w_state_nxt = ST_INIT_FETCH;
                else             w_cnt_nxt   = r_cnt - 32'd1;
            end

            ST_INIT_FETCH: begin
                if (w_entry == ROM_END) begin
                    w_init_done_nxt = 1'b1;
                    w_state_nxt     = ST_FRAME_IDLE;
                end else if (w_entry[ROM_DELAY_BIT]) begin
                    w_cnt_nxt     = 32'(w_entry[7:0]) * 32'(TICKS_PER_MS);
                    w_rom_idx_nxt = r_rom_idx + 1'b1;
                    w_state_nxt   = ST_DELAY;
                end else begin
                    w_spi_data_nxt = DATA_SIZE'(w_entry[8:0]);
                    w_rom_idx_nxt  = r_rom_idx + 1'b1;
                    w_ret_nxt      = ST_INIT_FETCH;
                    w_state_nxt    = ST_ISSUE;
                end
            end

            ST_FRAME_IDLE: begin
                if (frame_go) begin
                    w_win_idx_nxt = '0;
                    w_state_nxt   = ST_WIN;
                end
            end

            ST_WIN: begin
                if (r_win_idx == WIN_WORDS) begin
                    w_state_nxt = ST_PIX_HI;
                end else begin
                    w_spi_data_nxt = DATA_SIZE'(win_word(r_win_idx, COL_LAST, ROW_LAST));
                    w_win_idx_nxt  = r_win_idx + 4'd1;
                    w_ret_nxt      = ST_WIN;
                    w_state_nxt    = ST_ISSUE;
                end
            end

            ST_PIX_HI: begin
                pixel_rd       = 1'b1;
                w_pix_lo_nxt   = pixel_data[7:0];
                w_spi_data_nxt = DATA_SIZE'({1'b1, pixel_data[15:8]});
                w_ret_nxt      = ST_PIX_LO;
                w_state_nxt    = ST_ISSUE;
            end

            ST_PIX_LO: begin
                w_spi_data_nxt = DATA_SIZE'({1'b1, r_pix_lo});
                w_ret_nxt      = ST_PIX_NEXT;
                w_state_nxt    = ST_ISSUE;
            end

            ST_PIX_NEXT: begin
                w_state_nxt = ST_PIX_HI;
                if (r_x == X_LAST) begin
                    w_x_nxt = '0;
                    if (r_y == Y_LAST) begin
                        w_y_nxt     = '0;
                        frame_done  = 1'b1;
                        w_state_nxt = ST_FRAME_IDLE;
                    end else begin
                        w_y_nxt = r_y + 9'd1;
                    end
                end else begin
                    w_x_nxt = r_x + 9'd1;
                end
            end

            // The strobe is gated by spi_idle so it is only ever presented
            // to an idle master, and lasts exactly the one accepting cycle.
            ST_ISSUE: begin
                if (spi_idle) begin
                    spi_valid   = 1'b1;
                    w_state_nxt = ST_WAIT_BUSY;
                end
            end

            ST_WAIT_BUSY: begin
                if (!spi_idle) w_state_nxt = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                if (spi_idle) w_state_nxt = r_ret;
            end

            default: w_state_nxt = ST_HW_RST;
        endcase
    end

    assign spi_data  = r_spi_data;
    assign lcd_rst_n = (r_state != ST_HW_RST);
    assign busy      = (r_state != ST_FRAME_IDLE);
    assign init_done = r_init_done;
    assign pixel_x   = r_x;
    assign pixel_y   = r_y;

endmodule
